pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/sat_counter.sv | 29 ++
 rtl/pipeline_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipeline_stage_reg.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipeline stage register: default payload and
//   counter widths, and the skid-buffer occupancy state type.
//   No ports.
package pipeline_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at its all-ones value instead of wrapping.
//   Ports:
//     clk_i  in   clock, counts on rising edge
//     clear  in   asynchronous clear, active high (driven from the stage reset)
//     inc    in   count enable for this cycle
//     count  out  current count, CNT_W bits
module sat_counter
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk_i or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
//   One valid/ready pipeline stage with a flush input and a saturating count
//   of cycles spent stalled (output valid, downstream not ready).
//   Build option: define PIPE_STAGE_SKID_EN to add a skid entry so that
//   ready_o comes straight from the state register; otherwise a single
//   register with combinational ready_o = !valid_o || ready_i.
//   Ports:
//     clk_i        in   clock
//     rst_n_i      in   asynchronous reset, active low
//     flush_i      in   drop all held entries and the beat offered this cycle
//     valid_i      in   upstream payload valid
//     ready_o      out  stage can accept this cycle
//     data_i       in   upstream payload, DATA_W bits
//     valid_o      out  downstream payload valid
//     ready_i      in   downstream accepts this cycle
//     data_o       out  downstream payload, DATA_W bits
//     stall_cnt_o  out  saturating stalled-cycle count, CNT_W bits
//
//   Skid state (PIPE_STAGE_SKID_EN only):
//     state | meaning
//     EMPTY | nothing held, valid_o=0, ready_o=1
//     BUSY  | main entry valid, ready_o=1
//     FULL  | main and skid entries valid, ready_o=0
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic accept;
  logic emit;
  logic stall;

  assign accept = valid_i && ready_o;
  assign emit   = valid_o && ready_i;
  assign stall  = valid_o && !ready_i && !flush_i;

`ifdef PIPE_STAGE_SKID_EN

  skid_state_e       state;
  skid_state_e       state_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;

  assign ready_o = (state != FULL);
  assign valid_o = (state != EMPTY);
  assign data_o  = main_data;

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = BUSY;
        BUSY: begin
          if (accept && !emit)      state_nxt = FULL;
          else if (!accept && emit) state_nxt = EMPTY;
        end
        FULL:  if (emit) state_nxt = BUSY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush only clears occupancy; payload registers keep their last contents.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_data <= '0;
      skid_data <= '0;
    end else if (!flush_i) begin
      case (state)
        EMPTY: if (accept) main_data <= data_i;
        BUSY: begin
          if (accept && emit) main_data <= data_i;
          else if (accept)    skid_data <= data_i;
        end
        FULL:  if (emit) main_data <= skid_data;
        default: ;
      endcase
    end
  end

`else

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

`endif

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .clear (!rst_n_i),
    .inc   (stall),
    .count (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
module tb_pipeline_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_i;
  logic [63:0] data_i;

  logic        ready_o, valid_o;
  logic [63:0] data_o;
  logic [15:0] stall_cnt_o;

  logic        ready4, valid4;
  logic [63:0] data4;
  logic [3:0]  stall4;

  int checks = 0;
  int errors = 0;

  // Reference: queue of accepted-but-not-yet-delivered beats, plus stall totals.
  logic [63:0] mq[$];
  int          m_stall;
  int          m_stall4;

  pipeline_stage_reg #(.DATA_W(64), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .stall_cnt_o(stall_cnt_o)
  );

  pipeline_stage_reg #(.DATA_W(64), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready4), .data_i(data_i),
    .valid_o(valid4), .ready_i(ready_i), .data_o(data4),
    .stall_cnt_o(stall4)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || ready_i;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stall  = 0;
    m_stall4 = 0;
  endtask

  task automatic check_all(input string tag);
    logic mv;
    mv = (mq.size() > 0);
    chk({tag, ":valid_o"}, 64'(valid_o), 64'(mv));
    chk({tag, ":ready_o"}, 64'(ready_o), 64'(model_ready()));
    chk({tag, ":valid4"},  64'(valid4),  64'(mv));
    chk({tag, ":stall"},   64'(stall_cnt_o), 64'(m_stall));
    chk({tag, ":stall4"},  64'(stall4),      64'(m_stall4));
    if (mv) begin
      chk({tag, ":data_o"}, data_o, mq[0]);
      chk({tag, ":data4"},  data4,  mq[0]);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
  endtask

  // Checks the pre-edge outputs, then advances one clock and the model with it.
  task automatic step(input string tag);
    logic acc, pop, stl;
    #3;
    check_all(tag);
    acc = valid_i && model_ready();
    pop = (mq.size() > 0) && ready_i;
    stl = (mq.size() > 0) && !ready_i && !flush_i;
    @(posedge clk_i);
    if (flush_i) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(data_i);
    end
    if (stl) begin
      if (m_stall < 65535) m_stall++;
      if (m_stall4 < 15)   m_stall4++;
    end
    #1;
  endtask

  initial begin
    int s0;
    model_reset();
    rst_n_i = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0);

    // Held in reset with a beat offered: nothing gets in.
    repeat (3) begin
      @(posedge clk_i);
      #1;
      chk("rst:valid_o", 64'(valid_o), 64'd0);
      chk("rst:data_o",  data_o,       64'd0);
      chk("rst:stall",   64'(stall_cnt_o), 64'd0);
      chk("rst:ready_o", 64'(ready_o), 64'd1);
    end
    rst_n_i = 1'b1;
    step("rst_rel");
    chk("first_beat:data", data_o, 64'hDEAD_BEEF);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (2) step("drain0");

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0);
      step("stream");
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (2) step("stream_tail");

    // Hold under stall.
    s0 = m_stall;
    drive(1'b1, 64'd5, 1'b0, 1'b0);
    step("hold_a");
    drive(1'b1, 64'd6, 1'b0, 1'b0);
    repeat (3) step("hold_b");
    chk("hold:data5",  data_o, 64'd5);
    chk("hold:stall3", 64'(stall_cnt_o), 64'(s0 + 3));
    drive(1'b1, 64'd6, 1'b1, 1'b0);
    step("release");
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (3) step("release_tail");

    // Flush with both entries occupied and a beat on the input.
    drive(1'b1, 64'd7, 1'b0, 1'b0);
    step("fill7");
    drive(1'b1, 64'd9, 1'b0, 1'b0);
    step("fill9");
    drive(1'b1, 64'd11, 1'b0, 1'b1);
    step("flush");
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    chk("flush:valid_o", 64'(valid_o), 64'd0);
    repeat (4) step("post_flush");

    // Long stall saturates the 4-bit counter.
    drive(1'b1, 64'd3, 1'b0, 1'b0);
    repeat (20) step("sat");
    chk("sat:stall4", 64'(stall4), 64'd15);
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (3) step("sat_drain");

    // Asynchronous reset in the middle of a stall.
    #2 rst_n_i = 1'b0;
    #1 rst_n_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    drive(1'b1, 64'hA, 1'b0, 1'b0);
    step("mid_a");
    repeat (2) step("mid_stall");
    chk("mid:stall2", 64'(stall_cnt_o), 64'd2);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async:stall", 64'(stall_cnt_o), 64'd0);
    chk("async:valid", 64'(valid_o),     64'd0);
    chk("async:stall4", 64'(stall4),     64'd0);
    model_reset();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    step("after_async");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      step("rand");
    end
    drive(1'b0, 64'd0, 1'b1, 1'b0);
    repeat (3) step("final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
